// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm generator / capture blocks.
//   - capState_t : capture FSM state encoding (IDLE, MEASURE)
//   - *_DEF      : default widths, synchroniser depth and burst timeout
//   - PWM_*      : reference period / high-time used by pwm benches
package pwm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } capState_t;

  localparam int CNT_W_DEF       = 16;
  localparam int BCNT_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF     = 4096;

  localparam int PWM_PERIOD_DEF  = 500;
  localparam int PWM_HIGH_DEF    = 450;

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement bundle between a PWM source / result consumer and pwm_capture.
//   pwmIn      : waveform under measurement
//   measPeriod : cycles between the last two rises
//   measHigh   : high cycles within that period
//   measValid  : one-cycle strobe, measPeriod/measHigh updated
//   burstLen   : rises counted in the burst just ended
//   burstDone  : one-cycle strobe, burstLen updated
//   busy       : capture is inside a burst
// master = side that drives pwmIn and consumes results, slave = pwm_capture.
interface pwm_capture_if #(
  parameter int CNT_W  = 16,
  parameter int BCNT_W = 8
) ();

  logic              pwmIn;
  logic [CNT_W-1:0]  measPeriod;
  logic [CNT_W-1:0]  measHigh;
  logic              measValid;
  logic [BCNT_W-1:0] burstLen;
  logic              burstDone;
  logic              busy;

  modport master (
    output pwmIn,
    input  measPeriod, measHigh, measValid, burstLen, burstDone, busy
  );

  modport slave (
    input  pwmIn,
    output measPeriod, measHigh, measValid, burstLen, burstDone, busy
  );

endinterface

// File: rtl/pwm_sync_edge.sv
// Synchroniser plus edge detector for a single-bit input.
//   clk, rst : clock and synchronous active-high reset
//   asyncIn  : raw input
//   sync     : input after SYNC_STAGES flops
//   rise     : sync went 0 -> 1 this cycle
//   fall     : sync went 1 -> 0 this cycle
// rise and fall share the same SYNC_STAGES latency, so intervals measured
// between them are not biased by the synchroniser.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic asyncIn,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   hist;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncReg <= '0;
      hist    <= 1'b0;
    end else begin
      syncReg[0] <= asyncIn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        syncReg[i] <= syncReg[i-1];
      end
      hist <= syncReg[SYNC_STAGES-1];
    end
  end

  assign sync = syncReg[SYNC_STAGES-1];
  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time / burst-length measurement.
//   clk, rst : clock and synchronous active-high reset
//   cap      : pwm_capture_if slave (pwmIn in; measPeriod, measHigh,
//              measValid, burstLen, burstDone, busy out)
// A burst starts on a rise seen in IDLE and ends once TIMEOUT cycles pass
// without a further rise. Every rise inside a burst reports the period and
// high time of the pulse that just completed. Results hold between strobes.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int BCNT_W      = BCNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input logic         clk,
  input logic         rst,
  pwm_capture_if.slave cap
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [BCNT_W-1:0] BCNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(TIMEOUT - 1);

  logic sync, rise, fall;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .asyncIn(cap.pwmIn),
    .sync   (sync),
    .rise   (rise),
    .fall   (fall)
  );

  capState_t         state;
  logic [CNT_W-1:0]  perCnt;
  logic [CNT_W-1:0]  hiCnt;
  logic [CNT_W-1:0]  hiLatch;
  logic [CNT_W-1:0]  idleCnt;
  logic [BCNT_W-1:0] burstCnt;
  logic              fallSeen;

  logic [CNT_W-1:0]  measPeriodQ;
  logic [CNT_W-1:0]  measHighQ;
  logic              measValidQ;
  logic [BCNT_W-1:0] burstLenQ;
  logic              burstDoneQ;
  logic              busyQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      perCnt      <= '0;
      hiCnt       <= '0;
      hiLatch     <= '0;
      idleCnt     <= '0;
      burstCnt    <= '0;
      fallSeen    <= 1'b0;
      measPeriodQ <= '0;
      measHighQ   <= '0;
      measValidQ  <= 1'b0;
      burstLenQ   <= '0;
      burstDoneQ  <= 1'b0;
      busyQ       <= 1'b0;
    end else begin
      measValidQ <= 1'b0;
      burstDoneQ <= 1'b0;

      // The rise cycle is itself the first cycle of both period and high time.
      if (rise) begin
        perCnt   <= CNT_W'(1);
        hiCnt    <= CNT_W'(1);
        fallSeen <= 1'b0;
      end else begin
        if (perCnt != CNT_MAX)         perCnt <= perCnt + 1'b1;
        if (sync && hiCnt != CNT_MAX)  hiCnt  <= hiCnt + 1'b1;
      end

      if (fall) begin
        hiLatch  <= hiCnt;
        fallSeen <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state    <= MEASURE;
            busyQ    <= 1'b1;
            burstCnt <= BCNT_W'(1);
            idleCnt  <= '0;
          end
        end

        MEASURE: begin
          // A rise on the timeout cycle takes priority and extends the burst.
          if (rise) begin
            measPeriodQ <= perCnt;
            measHighQ   <= fallSeen ? hiLatch : perCnt;
            measValidQ  <= 1'b1;
            if (burstCnt != BCNT_MAX) burstCnt <= burstCnt + 1'b1;
            idleCnt     <= '0;
          end else if (idleCnt == IDLE_LAST) begin
            burstLenQ  <= burstCnt;
            burstDoneQ <= 1'b1;
            state      <= IDLE;
            busyQ      <= 1'b0;
          end else begin
            idleCnt <= idleCnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign cap.measPeriod = measPeriodQ;
  assign cap.measHigh   = measHighQ;
  assign cap.measValid  = measValidQ;
  assign cap.burstLen   = burstLenQ;
  assign cap.burstDone  = burstDoneQ;
  assign cap.busy       = busyQ;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture.
// A reference model watches the pwmIn sample stream (one sample per clock
// edge) and derives measurements from rise/fall edge indices: period is the
// distance between rises, high time the distance from a rise to the next
// fall, and a burst ends when TIMEOUT samples pass after a rise without
// another rise. Expected strobes carry the edge index at which they must be
// visible (sampling edge + SYNC_STAGES). A separate monitor compares every
// strobe the DUT presents against the queues.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int CNT_W       = CNT_W_DEF;
  localparam int BCNT_W      = BCNT_W_DEF;
  localparam int SYNC_STAGES = SYNC_STAGES_DEF;
  localparam int TIMEOUT     = TIMEOUT_DEF;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int BCNT_MAX    = (1 << BCNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_W(CNT_W), .BCNT_W(BCNT_W)) cap ();

  pwm_capture #(
    .CNT_W      (CNT_W),
    .BCNT_W     (BCNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cap(cap)
  );

  typedef struct {
    int per;
    int hi;
    int at;
  } measExp_t;

  typedef struct {
    int len;
    int at;
  } burstExp_t;

  measExp_t  measQ[$];
  burstExp_t burstQ[$];

  int errors  = 0;
  int checks  = 0;
  int edgeNum = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeNum);
    end
  endtask

  // ---------------- reference model ----------------
  initial begin
    bit        prev, inBurst, fallSeen, s;
    int        lastRise, lastFall, cnt, per;
    measExp_t  m;
    burstExp_t b;
    prev = 0; inBurst = 0; fallSeen = 0;
    lastRise = 0; lastFall = 0; cnt = 0;
    forever begin
      @(posedge clk);
      edgeNum++;
      if (rst) begin
        prev    = 0;
        inBurst = 0;
      end else begin
        s = cap.pwmIn;
        if (!s && prev) begin
          lastFall = edgeNum;
          fallSeen = 1;
        end
        if (s && !prev) begin
          if (inBurst) begin
            per   = (edgeNum - lastRise > CNT_MAX) ? CNT_MAX : edgeNum - lastRise;
            m.per = per;
            m.hi  = fallSeen ? lastFall - lastRise : per;
            m.at  = edgeNum + SYNC_STAGES;
            measQ.push_back(m);
            if (cnt < BCNT_MAX) cnt++;
          end else begin
            inBurst = 1;
            cnt     = 1;
          end
          lastRise = edgeNum;
          fallSeen = 0;
        end else if (inBurst && edgeNum - lastRise == TIMEOUT) begin
          b.len = cnt;
          b.at  = edgeNum + SYNC_STAGES;
          burstQ.push_back(b);
          inBurst = 0;
        end
        prev = s;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    measExp_t  m;
    burstExp_t b;
    int        lastPer, lastHi;
    lastPer = 0; lastHi = 0;
    forever begin
      @(negedge clk);
      if (cap.measValid) begin
        if (measQ.size() == 0) begin
          check("measValid with nothing expected", int'(cap.measValid), 0);
        end else begin
          m = measQ.pop_front();
          check("measPeriod", int'(cap.measPeriod), m.per);
          check("measHigh", int'(cap.measHigh), m.hi);
          check("measValid edge", edgeNum, m.at);
          check("busy during burst", int'(cap.busy), 1);
          lastPer = m.per;
          lastHi  = m.hi;
        end
      end
      if (cap.burstDone) begin
        if (burstQ.size() == 0) begin
          check("burstDone with nothing expected", int'(cap.burstDone), 0);
        end else begin
          b = burstQ.pop_front();
          check("burstLen", int'(cap.burstLen), b.len);
          check("burstDone edge", edgeNum, b.at);
          check("busy after burst", int'(cap.busy), 0);
          check("measPeriod held", int'(cap.measPeriod), lastPer);
          check("measHigh held", int'(cap.measHigh), lastHi);
        end
      end
      if (rst) begin
        lastPer = 0;
        lastHi  = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 cap.pwmIn = v;
    end
  endtask

  task automatic pulses(input int n, input int per, input int hi);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, hi);
      drive(1'b0, per - hi);
    end
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic checkCleared(input string tag);
    check({tag, " measPeriod"}, int'(cap.measPeriod), 0);
    check({tag, " measHigh"}, int'(cap.measHigh), 0);
    check({tag, " burstLen"}, int'(cap.burstLen), 0);
    check({tag, " busy"}, int'(cap.busy), 0);
    check({tag, " measValid"}, int'(cap.measValid), 0);
    check({tag, " burstDone"}, int'(cap.burstDone), 0);
  endtask

  initial begin
    int n, per, hi, gapSel;
    rst       = 1'b1;
    cap.pwmIn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkCleared("reset");

    // 0 % duty: nothing happens
    drive(1'b0, 50);
    check("idle busy", int'(cap.busy), 0);

    // continuous 500/450 stream
    pulses(10, PWM_PERIOD_DEF, PWM_HIGH_DEF);
    drive(1'b0, TIMEOUT + 20);

    // 8-pulse burst 20/10, long idle
    pulses(8, 20, 10);
    drive(1'b0, 5000);

    // 16-pulse burst then 8-pulse burst, no carry-over
    pulses(16, 500, 250);
    drive(1'b0, TIMEOUT + 20);
    pulses(8, 500, 250);
    drive(1'b0, TIMEOUT + 20);

    // long high, 1-cycle low, then constant high past the timeout
    drive(1'b1, 1499);
    drive(1'b0, 1);
    drive(1'b1, TIMEOUT + 100);
    drive(1'b0, 50);

    // reset mid-high inside a burst, re-arm while still high
    pulses(3, 500, 300);
    drive(1'b1, 100);
    pulseReset();
    @(negedge clk);
    checkCleared("mid-burst reset");
    drive(1'b1, 200);
    drive(1'b0, 200);
    pulses(2, 500, 300);
    drive(1'b0, TIMEOUT + 20);

    // minimum period, then a rise exactly on the timeout boundary
    pulses(10, 2, 1);
    drive(1'b0, TIMEOUT - 2);
    pulses(1, 2, 1);
    drive(1'b0, TIMEOUT + 20);

    // randomized bursts with gaps around the timeout boundary
    for (int seg = 0; seg < 3; seg++) begin
      n      = $urandom_range(1, 6);
      per    = $urandom_range(2, 60);
      hi     = $urandom_range(1, per - 1);
      gapSel = $urandom_range(0, 3);
      pulses(n, per, hi);
      case (gapSel)
        0:       drive(1'b0, $urandom_range(0, 200));
        1:       drive(1'b0, TIMEOUT - per);
        2:       drive(1'b0, TIMEOUT - per + 1);
        default: drive(1'b0, TIMEOUT + $urandom_range(0, 50));
      endcase
    end
    pulses(2, 40, 13);
    drive(1'b0, TIMEOUT + 20);

    check("pending measurements", measQ.size(), 0);
    check("pending bursts", burstQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
